// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
// Optional packet lock is enabled with HANDSHAKE_ARB_PKT_LOCK_EN.
package handshake_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First valid index strictly after ptr, wrapping modulo n (n <= 32, ptr < n).
    function automatic int unsigned rr_pick(
        input logic [31:0] valid,
        input int unsigned ptr,
        input int unsigned n
    );
        int unsigned grant;
        int unsigned idx;
        logic        found;
        grant = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 32; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k <= n) && !found && (((valid >> idx) & 32'd1) != 32'd0)) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational round-robin pick: rotate past ptr, priority-encode, unrotate.
// Shared by both builds of handshake_rr_arbiter (HANDSHAKE_ARB_PKT_LOCK_EN agnostic).
module handshake_rr_pick
    import handshake_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    always_comb begin
        grant     = IDX_W'(rr_pick(32'(valid), 32'(ptr), NUM_REQ));
        any_valid = |valid;
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ handshake sources into one registered output stage.
// Define HANDSHAKE_ARB_PKT_LOCK_EN to add s_last/m_last and hold the grant for a whole packet.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8,
    localparam int unsigned IDX_W    = idx_bits(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             s_valid,
    output logic [NUM_REQ-1:0]             s_ready,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_data,
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]             s_last,
    output logic                           m_last,
`endif
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_BITS-1:0]           m_data,
    output logic [IDX_W-1:0]               m_sel
);

    arb_state_t             state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       pick_grant;
    logic                   pick_any;
    logic [IDX_W-1:0]       grant;
    logic                   grant_ok;
    logic                   load;
    logic                   accept;
    logic [DATA_BITS-1:0]   grant_data;

    handshake_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid     (s_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .any_valid (pick_any)
    );

    always_comb begin
        load = !m_valid || m_ready;
        // While locked the grant stays on the packet owner even if it pauses.
        if (state_q == LOCK) begin
            grant    = ptr_q;
            grant_ok = s_valid[ptr_q];
        end else begin
            grant    = pick_grant;
            grant_ok = pick_any;
        end
        accept     = !rst && load && grant_ok;
        s_ready    = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                grant_data = s_data[i*DATA_BITS +: DATA_BITS];
                s_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            state_q <= ARB;
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
            m_last  <= 1'b0;
`endif
        end else if (load) begin
            m_valid <= accept;
            if (accept) begin
                m_data <= grant_data;
                m_sel  <= grant;
                ptr_q  <= grant;
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
                m_last  <= s_last[grant];
                state_q <= s_last[grant] ? ARB : LOCK;
`else
                state_q <= ARB;
`endif
            end
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed self-checking bench for handshake_rr_arbiter (lock test with HANDSHAKE_ARB_PKT_LOCK_EN).
module tb_handshake_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_sel;
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
    logic [3:0]  s_last;
    logic        m_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(
        .NUM_REQ   (4),
        .DATA_BITS (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
        .s_last  (s_last),
        .m_last  (m_last),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sel   (m_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        s_valid = '0;
        m_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 4'hF;
        m_ready = 1'b1;
        s_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (s_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_s_ready cyc%0d: got %b, expected 0000", c, s_ready);
            end
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_m_valid cyc%0d: got %b, expected 0", c, m_valid);
            end
        end
        n_checks++;
        if (m_data !== 8'h00 || m_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_m_data_sel: got %h/%0d, expected 00/0", m_data, m_sel);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_grant: got %b, expected 0001", s_ready);
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_sel !== 2'd0 || m_data !== 8'hA1) begin
            n_fail++;
            $display("FAIL first_beat: got v=%b sel=%0d d=%h, expected v=1 sel=0 d=a1",
                     m_valid, m_sel, m_data);
        end
        s_valid = '0;
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got %b, expected 0", m_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [1:0] exp_s [5];
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        m_ready = 1'b1;
        s_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        s_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_sel !== exp_s[i]) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got v=%b d=%h sel=%0d, expected v=1 d=%h sel=%0d",
                         i, m_valid, m_data, m_sel, exp_d[i], exp_s[i]);
            end
        end
        s_valid = '0;
        tick();
    endtask

    task automatic test_single_source();
        apply_reset();
        m_ready = 1'b1;
        s_data  = '0;
        s_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            s_data[16 +: 8] = 8'h5A + 8'(i);
            #1;
            n_checks++;
            if (s_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_ready%0d: got %b, expected 0100", i, s_ready);
            end
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h5A + 8'(i) || m_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b d=%h sel=%0d, expected v=1 d=%h sel=2",
                         i, m_valid, m_data, m_sel, 8'h5A + 8'(i));
            end
        end
        s_valid = '0;
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got %b, expected 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic       mv, load_m;
        logic [7:0] md, seq1, seq3;
        logic [1:0] ms, src;
        logic [3:0] exp_rdy;
        int         k, drained;
        mv = 1'b0; md = '0; ms = '0; seq1 = '0; seq3 = '0; k = 0; drained = 0;
        apply_reset();
        s_data  = '0;
        s_valid = 4'b1010;
        for (int c = 0; c < 40; c++) begin
            m_ready          = 1'($urandom_range(0, 1));
            s_data[8 +: 8]   = 8'h10 + seq1;
            s_data[24 +: 8]  = 8'h30 + seq3;
            #1;
            load_m  = !mv || m_ready;
            src     = (k % 2 == 0) ? 2'd1 : 2'd3;
            exp_rdy = !load_m ? 4'b0000 : (src == 2'd1 ? 4'b0010 : 4'b1000);
            n_checks++;
            if (s_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_ready cyc%0d: got %b, expected %b", c, s_ready, exp_rdy);
            end
            if (m_valid && m_ready) drained++;
            tick();
            if (load_m) begin
                mv = 1'b1;
                ms = src;
                if (src == 2'd1) begin
                    md   = 8'h10 + seq1;
                    seq1 = seq1 + 8'd1;
                end else begin
                    md   = 8'h30 + seq3;
                    seq3 = seq3 + 8'd1;
                end
                k++;
            end
            n_checks++;
            if (m_valid !== mv || m_data !== md || m_sel !== ms) begin
                n_fail++;
                $display("FAIL bp_out cyc%0d: got v=%b d=%h sel=%0d, expected v=%b d=%h sel=%0d",
                         c, m_valid, m_data, m_sel, mv, md, ms);
            end
        end
        s_valid = '0;
        m_ready = 1'b1;
        #1;
        if (m_valid && m_ready) drained++;
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_final_empty: got %b, expected 0", m_valid);
        end
        n_checks++;
        if (drained != k) begin
            n_fail++;
            $display("FAIL bp_beat_count: got %0d, expected %0d", drained, k);
        end
    endtask

    task automatic test_reset_mid_beat();
        apply_reset();
        m_ready = 1'b0;
        s_data  = '0;
        s_data[7:0] = 8'hEE;
        s_valid = 4'b0001;
        tick();
        s_valid = '0;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL mid_load: got v=%b d=%h, expected v=1 d=ee", m_valid, m_data);
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hEE || s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_stall: got v=%b d=%h rdy=%b, expected v=1 d=ee rdy=0000",
                     m_valid, m_data, s_ready);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_valid: got %b, expected 0", m_valid);
        end
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_replay cyc%0d: got %b, expected 0", c, m_valid);
            end
        end
    endtask

`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [7:0] exp_d [4];
        logic [1:0] exp_s [4];
        logic       exp_l [4];
        exp_d = '{8'hAB, 8'hCD, 8'hEF, 8'h11};
        exp_s = '{2'd0, 2'd0, 2'd0, 2'd1};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        m_ready = 1'b1;
        s_data  = '0;
        s_data[15:8] = 8'h11;
        s_last  = 4'b0000;
        s_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) s_data[7:0] = exp_d[i];
            s_last[0] = (i == 2);
            if (i == 3) s_valid = 4'b0010;
            #1;
            if (i == 1) begin
                n_checks++;
                if (s_ready !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL lock_ready: got %b, expected 0001", s_ready);
                end
            end
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_sel !== exp_s[i]
                || m_last !== exp_l[i]) begin
                n_fail++;
                $display("FAIL lock_beat%0d: got d=%h sel=%0d last=%b, expected d=%h sel=%0d last=%b",
                         i, m_data, m_sel, m_last, exp_d[i], exp_s[i], exp_l[i]);
            end
        end
        s_valid = '0;
        tick();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        s_valid = '0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
        s_last  = '0;
`endif
        test_reset();
        test_round_robin();
        test_single_source();
        test_backpressure();
        test_reset_mid_beat();
`ifdef HANDSHAKE_ARB_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
